osd_uart_line_buffer: RTL and testbench
=======================================

Name: osd_uart_line_buffer

Overview:
Character line buffer placed directly upstream of osd_dem_uart's out_char/out_valid/out_ready interface. It collects characters from a system-side producer and releases them to the DEM-UART as atomic bursts. A burst is released on a line terminator, when the buffer is full, on an idle timeout, or on an explicit flush. This keeps debug-ring UART traffic line-granular, so one host-side message carries one whole line instead of single-character packets.

Parameters:
DEPTH, 16, buffer entries; power of two, >= 2
TIMEOUT, 1024, idle cycles after the last accepted char before a forced release; 0 disables the timeout
FLUSH_CHAR, 8'h0a, character that terminates a line and triggers release

Ports:
clk  input  1  clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_char  input  8  producer character
in_valid  input  1  producer character valid
in_ready  output  1  buffer accepts in_char this cycle
out_char  output  8  character toward osd_dem_uart out_char
out_valid  output  1  out_char valid
out_ready  input  1  osd_dem_uart accepts out_char
flush  input  1  single-cycle request to release the buffered chars
level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (rst_n low, asynchronous): state=FILL, rd/wr pointers=0, count=0, timer=0.
  - Outputs after reset: in_ready=1, out_valid=0, level=0, out_char=mem[0] (don't-care while out_valid=0).
- Handshakes:
  - Push when in_valid&in_ready; pop when out_valid&out_ready. Both are valid/ready; no combinational path from in_valid to in_ready.
  - Once out_valid is high, it stays high and out_char stays stable until the pop occurs.
- FSM, two states:
  - FILL: in_ready = (count<DEPTH); out_valid=0.
  - DRAIN: in_ready=0; out_valid = (count>0); out_char = mem[rd_ptr], a combinational read of registered storage.
- FILL->DRAIN is registered and takes effect next cycle. Triggers, any one of:
  - a pushed char equals FLUSH_CHAR;
  - a push makes count==DEPTH;
  - flush=1 with count>0, or flush=1 concurrent with a push;
  - TIMEOUT!=0 and timer==TIMEOUT-1 with count>0 and no push this cycle.
- Latency: the push of the triggering char is at cycle T; out_valid=1 at T+1 at the earliest.
- DRAIN->FILL: on the pop that makes count==0. in_ready=1 from the next cycle.
- Push and pop never occur in the same cycle, because the states are exclusive.
- Timer:
  - Cleared on every push, on entering DRAIN, and while count==0.
  - Otherwise increments in FILL and saturates at TIMEOUT-1.
  - Width is $clog2(TIMEOUT+1).
- Pointers: $clog2(DEPTH) bits, wrap naturally. count and level are $clog2(DEPTH)+1 bits, with level=count.
- Boundary conditions:
  - flush with count==0 and no push: ignored, stays in FILL.
  - Multiple triggers in the same cycle: a single transition.
  - flush during DRAIN: ignored.
  - Full in FILL: in_ready=0 for at most that cycle, since DRAIN follows.
  - FLUSH_CHAR is stored and forwarded like any other char, never stripped.
  - out_ready held low in DRAIN: holds indefinitely, no timeout applies.
  - rst_n asserted mid-DRAIN: buffered chars are discarded; after release the block is in FILL and empty.

Decomposition:
- Package osd_uart_pkg holds:
  - typedef logic [7:0] uart_char_t;
  - localparam UART_LF = 8'h0a;
  - enum lb_state_e {LB_FILL, LB_DRAIN}.
- Sub-module osd_uart_lb_mem: DEPTH x 8 register array with write port (we, waddr, wdata) and asynchronous read (raddr, rdata), no reset on data.
- The FSM, pointers and timer live in the top module.

Test Plan:
- DEPTH=16: push "Hello World!\n" (48 65 6c 6c 6f 20 57 6f 72 6c 64 21 0a), out_ready=1 -> out_valid stays 0 until the cycle after 0a is pushed. Then 13 chars appear in order on 13 consecutive cycles with in_ready=0 throughout. level returns to 0 and in_ready=1 the next cycle.
- DEPTH=4: push 41 42 43 44 45 with in_valid held -> after 44, in_ready drops. 41..44 drain, level 4->0. Then 45 is accepted and stays buffered (out_valid=0).
- TIMEOUT=8: push 78 once, in_valid=0 afterwards -> out_valid rises exactly 9 cycles after the push cycle and 78 is delivered.
- Backpressure: line 61 62 0a with out_ready toggling 1,0,0,1,... -> out_char is stable while stalled, order is 61 62 0a, no duplication or loss.
- flush pulse with count=2 -> DRAIN the next cycle. flush with count=0 -> level stays 0, out_valid stays 0, in_ready stays 1.
- Assert rst_n=0 after 1 of 5 chars is drained -> out_valid and level go to 0 asynchronously. After release, in_ready=1 and no stale char is emitted.

Source files
------------

// File: rtl/osd_uart_pkg.sv
// Shared types and constants for the OSD UART character path.
package osd_uart_pkg;

  typedef logic [7:0] uart_char_t;

  localparam uart_char_t UART_LF = 8'h0a;

  typedef enum logic {
    LB_FILL,
    LB_DRAIN
  } lb_state_e;

endpackage

// File: rtl/osd_uart_lb_mem.sv
// Character storage for the line buffer: write port plus asynchronous read.
module osd_uart_lb_mem
  import osd_uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  uart_char_t    wdata,
  input  logic [AW-1:0] raddr,
  output uart_char_t    rdata
);

  uart_char_t mem [DEPTH];

  // Data storage carries no reset; contents only matter once written.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/osd_uart_line_buffer.sv
// Line buffer ahead of the DEM-UART: collects characters and releases them
// as one uninterrupted burst on a terminator, full buffer, idle timeout or flush.
module osd_uart_line_buffer
  import osd_uart_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned TIMEOUT    = 1024,
  parameter uart_char_t  FLUSH_CHAR = UART_LF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  uart_char_t             in_char,
  input  logic                   in_valid,
  output logic                   in_ready,
  output uart_char_t             out_char,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  // A zero TIMEOUT still needs a one-bit timer so the declarations stay legal.
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CW-1:0] CNT_FULL    = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_FULL_M1 = CW'(DEPTH - 1);
  localparam logic [TW-1:0] TMR_LAST    = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  lb_state_e     state_q, state_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [TW-1:0] timer_q;

  logic push, pop, tmo_hit, enter_drain;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Idle release only fires when something is buffered and nothing arrives now.
  assign tmo_hit = (TIMEOUT != 0) && (timer_q == TMR_LAST) && (count_q != '0) && !push;

  assign enter_drain = (state_q == LB_FILL) && (state_d == LB_DRAIN);
  assign level       = count_q;

  osd_uart_lb_mem #(
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (in_char),
    .raddr (rd_ptr_q),
    .rdata (out_char)
  );

  // Next state and handshake outputs; outputs depend only on registered state.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      LB_FILL: begin
        in_ready = (count_q < CNT_FULL);
        if ((push && ((in_char == FLUSH_CHAR) || (count_q == CNT_FULL_M1))) ||
            (flush && ((count_q != '0) || push)) ||
            tmo_hit)
          state_d = LB_DRAIN;
      end
      LB_DRAIN: begin
        out_valid = (count_q != '0);
        if (pop && (count_q == CW'(1)))
          state_d = LB_FILL;
      end
      default: state_d = LB_FILL;
    endcase
  end

  // State, pointers and occupancy; push and pop are mutually exclusive by state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LB_FILL;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
        count_q  <= count_q + CW'(1);
      end else if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        count_q  <= count_q - CW'(1);
      end
    end
  end

  // Idle timer: runs only while filling with data held, saturates at its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else if (push || enter_drain || (state_q != LB_FILL) || (count_q == '0)) begin
      timer_q <= '0;
    end else if (timer_q != TMR_LAST) begin
      timer_q <= timer_q + TW'(1);
    end
  end

endmodule

// File: tb/tb_osd_uart_line_buffer.sv
// Directed bench for osd_uart_line_buffer: a DEPTH=16 instance with the default
// timeout and a DEPTH=4 instance with an 8-cycle idle timeout.
module tb_osd_uart_line_buffer;
  import osd_uart_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Instance A: DEPTH=16, TIMEOUT=1024
  uart_char_t a_in_char = '0;
  logic       a_in_valid = 1'b0;
  logic       a_in_ready;
  uart_char_t a_out_char;
  logic       a_out_valid;
  logic       a_out_ready = 1'b0;
  logic       a_flush = 1'b0;
  logic [4:0] a_level;

  // Instance B: DEPTH=4, TIMEOUT=8
  uart_char_t b_in_char = '0;
  logic       b_in_valid = 1'b0;
  logic       b_in_ready;
  uart_char_t b_out_char;
  logic       b_out_valid;
  logic       b_out_ready = 1'b0;
  logic       b_flush = 1'b0;
  logic [2:0] b_level;

  int checks = 0;
  int errors = 0;

  uart_char_t hello [13] = '{8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h20, 8'h57,
                             8'h6f, 8'h72, 8'h6c, 8'h64, 8'h21, 8'h0a};
  uart_char_t bp_line [3] = '{8'h61, 8'h62, 8'h0a};
  logic       bp_pat [4]  = '{1'b1, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  osd_uart_line_buffer #(.DEPTH(16), .TIMEOUT(1024), .FLUSH_CHAR(8'h0a)) u_a (
    .clk (clk), .rst_n (rst_n),
    .in_char (a_in_char), .in_valid (a_in_valid), .in_ready (a_in_ready),
    .out_char (a_out_char), .out_valid (a_out_valid), .out_ready (a_out_ready),
    .flush (a_flush), .level (a_level)
  );

  osd_uart_line_buffer #(.DEPTH(4), .TIMEOUT(8), .FLUSH_CHAR(8'h0a)) u_b (
    .clk (clk), .rst_n (rst_n),
    .in_char (b_in_char), .in_valid (b_in_valid), .in_ready (b_in_ready),
    .out_char (b_out_char), .out_valid (b_out_valid), .out_ready (b_out_ready),
    .flush (b_flush), .level (b_level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assumes the single char was pushed in the previous cycle with nothing after it.
  task automatic b_expect_timeout(input uart_char_t c);
    for (int k = 1; k <= 8; k++) begin
      chk("tmo_wait_valid", {31'b0, b_out_valid}, 32'd0);
      tick();
    end
    chk("tmo_valid", {31'b0, b_out_valid}, 32'd1);
    chk("tmo_char", {24'b0, b_out_char}, {24'b0, c});
    tick();
    chk("tmo_level_after", {29'b0, b_level}, 32'd0);
    chk("tmo_in_ready_after", {31'b0, b_in_ready}, 32'd1);
  endtask

  initial begin
    int e;

    // Reset values
    #12;
    chk("rst_a_in_ready", {31'b0, a_in_ready}, 32'd1);
    chk("rst_a_out_valid", {31'b0, a_out_valid}, 32'd0);
    chk("rst_a_level", {27'b0, a_level}, 32'd0);
    chk("rst_b_in_ready", {31'b0, b_in_ready}, 32'd1);
    chk("rst_b_level", {29'b0, b_level}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Line of 13 chars released on the terminator, drained back to back
    a_out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      chk("hello_fill_valid", {31'b0, a_out_valid}, 32'd0);
      chk("hello_fill_ready", {31'b0, a_in_ready}, 32'd1);
      chk("hello_fill_level", {27'b0, a_level}, i);
      a_in_char  = hello[i];
      a_in_valid = 1'b1;
      tick();
    end
    a_in_valid = 1'b0;
    for (int i = 0; i < 13; i++) begin
      chk("hello_drain_valid", {31'b0, a_out_valid}, 32'd1);
      chk("hello_drain_char", {24'b0, a_out_char}, {24'b0, hello[i]});
      chk("hello_drain_in_ready", {31'b0, a_in_ready}, 32'd0);
      chk("hello_drain_level", {27'b0, a_level}, 13 - i);
      tick();
    end
    chk("hello_end_level", {27'b0, a_level}, 32'd0);
    chk("hello_end_in_ready", {31'b0, a_in_ready}, 32'd1);
    chk("hello_end_valid", {31'b0, a_out_valid}, 32'd0);

    // Full trigger on DEPTH=4 with in_valid held
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("full_fill_ready", {31'b0, b_in_ready}, 32'd1);
      b_in_char = 8'h41 + 8'(i);
      tick();
    end
    b_in_char = 8'h45;
    for (int i = 0; i < 4; i++) begin
      chk("full_drain_in_ready", {31'b0, b_in_ready}, 32'd0);
      chk("full_drain_valid", {31'b0, b_out_valid}, 32'd1);
      chk("full_drain_char", {24'b0, b_out_char}, 32'h41 + i);
      chk("full_drain_level", {29'b0, b_level}, 4 - i);
      tick();
    end
    chk("full_refill_ready", {31'b0, b_in_ready}, 32'd1);
    chk("full_refill_level", {29'b0, b_level}, 32'd0);
    tick();
    b_in_valid = 1'b0;
    chk("full_45_level", {29'b0, b_level}, 32'd1);
    // 45 stays buffered until the idle timeout releases it
    b_expect_timeout(8'h45);

    // Idle timeout on a single char
    b_in_char  = 8'h78;
    b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    b_expect_timeout(8'h78);

    // Backpressure: out_ready 1,0,0,1,... while draining 61 62 0a
    a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_in_char  = bp_line[i];
      a_in_valid = 1'b1;
      tick();
    end
    a_in_valid = 1'b0;
    e = 0;
    for (int c = 0; c < 20 && e < 3; c++) begin
      chk("bp_valid", {31'b0, a_out_valid}, 32'd1);
      chk("bp_char", {24'b0, a_out_char}, {24'b0, bp_line[e]});
      a_out_ready = bp_pat[c % 4];
      tick();
      if (bp_pat[c % 4]) e++;
    end
    chk("bp_all_popped", e, 32'd3);
    chk("bp_end_level", {27'b0, a_level}, 32'd0);
    chk("bp_end_in_ready", {31'b0, a_in_ready}, 32'd1);

    // Flush with two chars buffered
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_char   = 8'h31;
    tick();
    a_in_char   = 8'h32;
    tick();
    a_in_valid  = 1'b0;
    chk("flush_pre_valid", {31'b0, a_out_valid}, 32'd0);
    chk("flush_pre_level", {27'b0, a_level}, 32'd2);
    a_flush = 1'b1;
    tick();
    chk("flush_drain_valid", {31'b0, a_out_valid}, 32'd1);
    chk("flush_drain_in_ready", {31'b0, a_in_ready}, 32'd0);
    chk("flush_drain_char0", {24'b0, a_out_char}, 32'h31);
    // flush still high in DRAIN has no effect
    a_out_ready = 1'b1;
    tick();
    a_flush = 1'b0;
    chk("flush_drain_char1", {24'b0, a_out_char}, 32'h32);
    tick();
    chk("flush_end_level", {27'b0, a_level}, 32'd0);
    chk("flush_end_in_ready", {31'b0, a_in_ready}, 32'd1);

    // Flush with an empty buffer is ignored
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("flush_empty_level", {27'b0, a_level}, 32'd0);
      chk("flush_empty_valid", {31'b0, a_out_valid}, 32'd0);
      chk("flush_empty_in_ready", {31'b0, a_in_ready}, 32'd1);
      tick();
    end

    // Reset in the middle of a drain discards buffered chars
    a_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_in_char = 8'h71 + 8'(i);
      a_flush   = (i == 4);
      tick();
    end
    a_in_valid = 1'b0;
    a_flush    = 1'b0;
    chk("rstmid_first_char", {24'b0, a_out_char}, 32'h71);
    chk("rstmid_first_valid", {31'b0, a_out_valid}, 32'd1);
    tick();
    a_out_ready = 1'b0;
    chk("rstmid_level4", {27'b0, a_level}, 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_async_valid", {31'b0, a_out_valid}, 32'd0);
    chk("rstmid_async_level", {27'b0, a_level}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("rstmid_post_ready", {31'b0, a_in_ready}, 32'd1);
      chk("rstmid_post_valid", {31'b0, a_out_valid}, 32'd0);
      chk("rstmid_post_level", {27'b0, a_level}, 32'd0);
      tick();
    end
    // A fresh line comes out without any stale char in front of it
    a_in_valid = 1'b1;
    a_in_char  = 8'h5a;
    tick();
    a_in_char  = 8'h0a;
    tick();
    a_in_valid = 1'b0;
    chk("rstmid_new_char0", {24'b0, a_out_char}, 32'h5a);
    chk("rstmid_new_level", {27'b0, a_level}, 32'd2);
    tick();
    chk("rstmid_new_char1", {24'b0, a_out_char}, 32'h0a);
    tick();
    chk("rstmid_new_end_level", {27'b0, a_level}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
